// File: rtl/program_counter_16b.sv
// ---------------------------------------------------------------------------
// program_counter_16b
//
// 16-bit 6502 program counter. It sits directly downstream of the
// falling-edge D flip-flop primitives, so all of its state updates on the
// falling edge of clock.
//
// Operations: HOLD, INC, LOAD_LO, LOAD_HI, LOAD_16 and relative BRANCH.
// Opcodes 6 and 7 are reserved and behave as HOLD.
//
// Optional feature macro: PC_BRANCH_FIXUP_EN
//   defined   : a page-crossing BRANCH adds only the offset to PCL, then
//               spends one extra FIXUP cycle adjusting PCH (6502-accurate).
//   undefined : BRANCH adds the sign-extended offset across all 16 bits in
//               one cycle. busy is tied low, and page_cross still pulses.
//
// Parameters:
//   RESET_PC   - PC value after reset (the reset-vector fetch address)
//
// Ports:
//   clock      in   system clock, falling-edge active
//   reset_n    in   synchronous active-low reset
//   op         in   [2:0] operation select
//   data_in    in   [7:0] byte for LOAD_LO/LOAD_HI, signed offset for BRANCH
//   addr_in    in   [15:0] value for LOAD_16
//   pc         out  [15:0] current program counter (registered)
//   busy       out  page-crossing fixup cycle pending
//   page_cross out  one-cycle pulse after a page-crossing BRANCH
// ---------------------------------------------------------------------------
module program_counter_16b #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  op,
  input  logic [7:0]  data_in,
  input  logic [15:0] addr_in,
  output logic [15:0] pc,
  output logic        busy,
  output logic        page_cross
);

  localparam logic [2:0] OP_HOLD    = 3'd0;
  localparam logic [2:0] OP_INC     = 3'd1;
  localparam logic [2:0] OP_LOAD_LO = 3'd2;
  localparam logic [2:0] OP_LOAD_HI = 3'd3;
  localparam logic [2:0] OP_LOAD_16 = 3'd4;
  localparam logic [2:0] OP_BRANCH  = 3'd5;

  // Low-byte branch sum. The carry XOR the offset sign gives a page
  // crossing: a forward offset that carries, or a backward one that does not
  // borrow (no carry out when adding the two's-complement byte).
  logic [8:0]         lo_sum;
  logic               crossing;
  logic signed [15:0] offset_sx;

  always_comb begin
    lo_sum    = {1'b0, pc[7:0]} + {1'b0, data_in};
    crossing  = lo_sum[8] ^ data_in[7];
    offset_sx = {{8{data_in[7]}}, data_in};
  end

`ifdef PC_BRANCH_FIXUP_EN

  typedef enum logic {
    IDLE  = 1'b0,
    FIXUP = 1'b1
  } state_t;

  state_t state;
  logic   dir_back;   // branch direction, captured at the BRANCH edge

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      busy       <= 1'b0;
      page_cross <= 1'b0;
      state      <= IDLE;
      dir_back   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy       <= 1'b0;
          page_cross <= 1'b0;
          case (op)
            OP_INC:     pc        <= pc + 16'd1;
            OP_LOAD_LO: pc[7:0]   <= data_in;
            OP_LOAD_HI: pc[15:8]  <= data_in;
            OP_LOAD_16: pc        <= addr_in;
            OP_BRANCH: begin
              pc[7:0] <= lo_sum[7:0];
              if (crossing) begin
                state      <= FIXUP;
                busy       <= 1'b1;
                page_cross <= 1'b1;
                dir_back   <= data_in[7];
              end
            end
            default:    pc        <= pc;
          endcase
        end
        FIXUP: begin
          // op and data_in are ignored here; PCH wraps naturally mod 256.
          if (dir_back) pc[15:8] <= pc[15:8] - 8'd1;
          else          pc[15:8] <= pc[15:8] + 8'd1;
          state      <= IDLE;
          busy       <= 1'b0;
          page_cross <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign busy = 1'b0;

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      page_cross <= 1'b0;
    end else begin
      page_cross <= 1'b0;
      case (op)
        OP_INC:     pc       <= pc + 16'd1;
        OP_LOAD_LO: pc[7:0]  <= data_in;
        OP_LOAD_HI: pc[15:8] <= data_in;
        OP_LOAD_16: pc       <= addr_in;
        OP_BRANCH: begin
          pc         <= $unsigned($signed(pc) + offset_sx);
          page_cross <= crossing;
        end
        default:    pc       <= pc;
      endcase
    end
  end

`endif

endmodule
